// File: rtl/dram_responder.sv
// dram_responder: round-robin memory-side responder for NUM_CORES DRAM initiator
// ports sharing one byte-wide data memory. One access at a time, IDLE -> ACCESS
// -> RESP, with a one-cycle per-core acknowledge pulse.
// Optional build macro DRAM_RESP_ERR_EN enables the sticky o_err detector.
module dram_responder #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned AW        = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_CORES*AW-1:0] i_dram_addr,
  input  logic [NUM_CORES*2-1:0]  i_dram_read,
  input  logic [NUM_CORES*2-1:0]  i_dram_write,
  input  logic [NUM_CORES*8-1:0]  i_dram_wdata,
  output logic [NUM_CORES*8-1:0]  o_dram_rdata,
  output logic [NUM_CORES-1:0]    o_ack,
  output logic                    o_busy,
  output logic                    o_err
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [1:0] CODE_REQ = 2'b01;

  logic [1:0]             state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          gnt_q, gnt_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic                   wr_q, wr_d;
  logic [7:0]             wdata_q, wdata_d;
  logic [NUM_CORES-1:0]   ack_q, ack_d;
  logic                   busy_q, busy_d;
  logic [NUM_CORES*8-1:0] rdata_q, rdata_d;

  logic [7:0]             mem [DEPTH];

  logic [NUM_CORES-1:0]   req_c;
  logic                   found_c;
  logic [PW-1:0]          pick_c;
  int unsigned            cand_c;
  logic                   in_range_c;
  logic [IW-1:0]          idx_c;
  logic [7:0]             mem_rd_c;
  logic                   mem_we_c;

  // Per-core request decode: only code 01 on either line counts as a request
  always_comb begin
    req_c = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      req_c[k] = (i_dram_read[2*k +: 2] == CODE_REQ) ||
                 (i_dram_write[2*k +: 2] == CODE_REQ);
    end
  end

  // Round-robin pick: first requester at or after the pointer, wrapping
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    cand_c  = 0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      cand_c = (32'(ptr_q) + i) % NUM_CORES;
      if (!found_c && req_c[PW'(cand_c)]) begin
        found_c = 1'b1;
        pick_c  = PW'(cand_c);
      end
    end
  end

  // Latched-address decode and memory read port
  always_comb begin
    in_range_c = (32'(addr_q) < DEPTH);
    idx_c      = addr_q[IW-1:0];
    mem_rd_c   = mem[idx_c];
  end

  // Next-state logic: grant in IDLE, perform access in ACCESS, release in RESP
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    ack_d    = '0;
    rdata_d  = rdata_q;
    mem_we_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found_c) begin
          gnt_d   = pick_c;
          addr_d  = i_dram_addr[32'(pick_c)*AW +: AW];
          // Write wins when both codes request; the read is dropped
          wr_d    = (i_dram_write[32'(pick_c)*2 +: 2] == CODE_REQ);
          wdata_d = i_dram_wdata[32'(pick_c)*8 +: 8];
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        ack_d[gnt_q] = 1'b1;
        if (wr_q) begin
          mem_we_c = in_range_c;
        end else begin
          rdata_d[32'(gnt_q)*8 +: 8] = in_range_c ? mem_rd_c : 8'h00;
        end
        ptr_d   = (32'(gnt_q) == NUM_CORES - 1) ? '0 : gnt_q + PW'(1);
        state_d = S_RESP;
      end
      S_RESP: begin
        // Requests ignored here so the served core can drop its lines
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers; reset abandons any access in flight
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  // Data memory write port; contents survive reset
  always_ff @(posedge i_clk) begin
    if (mem_we_c) begin
      mem[idx_c] <= wdata_q;
    end
  end

  assign o_dram_rdata = rdata_q;
  assign o_ack        = ack_q;
  assign o_busy       = busy_q;

`ifdef DRAM_RESP_ERR_EN
  logic err_q, err_d;
  logic bad_code_c;
  logic rw_both_c;

  // Sticky error: reserved codes, read+write on one core, out-of-range access
  always_comb begin
    bad_code_c = 1'b0;
    rw_both_c  = 1'b0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (i_dram_read[2*k+1] || i_dram_write[2*k+1]) begin
        bad_code_c = 1'b1;
      end
      if ((i_dram_read[2*k +: 2] == CODE_REQ) && (i_dram_write[2*k +: 2] == CODE_REQ)) begin
        rw_both_c = 1'b1;
      end
    end
    err_d = err_q | bad_code_c | rw_both_c | ((state_q == S_ACCESS) && !in_range_c);
  end

  // Error flag register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_dram_responder.sv
// Scoreboard bench for dram_responder: expected completions are queued as
// requests are driven and popped as acknowledges appear.
module tb_dram_responder;

  localparam int unsigned NC  = 4;
  localparam int unsigned AWT = 16;

  logic                i_clk;
  logic                i_rst;
  logic [NC*AWT-1:0]   i_dram_addr;
  logic [NC*2-1:0]     i_dram_read;
  logic [NC*2-1:0]     i_dram_write;
  logic [NC*8-1:0]     i_dram_wdata;
  logic [NC*8-1:0]     o_dram_rdata;
  logic [NC-1:0]       o_ack;
  logic                o_busy;
  logic                o_err;

  typedef struct {
    int         core;
    bit         chk_rd;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   hold [NC];
  int   n_chk;
  int   n_fail;
  int   busy_cnt;
  int   first_ack;
  int   exp_err;

  dram_responder #(.NUM_CORES(NC), .DEPTH(1024), .AW(AWT)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_dram_addr  (i_dram_addr),
    .i_dram_read  (i_dram_read),
    .i_dram_write (i_dram_write),
    .i_dram_wdata (i_dram_wdata),
    .o_dram_rdata (o_dram_rdata),
    .o_ack        (o_ack),
    .o_busy       (o_busy),
    .o_err        (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [1:0] rd, input logic [1:0] wr,
                         input logic [15:0] a, input logic [7:0] d, input int n_hold);
    i_dram_read[2*k +: 2]    = rd;
    i_dram_write[2*k +: 2]   = wr;
    i_dram_addr[AWT*k +: AWT] = a;
    i_dram_wdata[8*k +: 8]   = d;
    hold[k]                  = n_hold;
  endtask

  task automatic clr_req(input int k);
    i_dram_read[2*k +: 2]  = 2'b00;
    i_dram_write[2*k +: 2] = 2'b00;
    hold[k]                = 0;
  endtask

  task automatic push(input int core, input bit chk_rd, input logic [7:0] data);
    exp_t e;
    e.core   = core;
    e.chk_rd = chk_rd;
    e.data   = data;
    exp_q.push_back(e);
  endtask

  function automatic bit pending();
    bit p;
    p = 1'b0;
    for (int k = 0; k < NC; k++) if (hold[k] > 0) p = 1'b1;
    return p;
  endfunction

  // Run cycles, matching acks against the scoreboard and releasing cores
  task automatic service(input int budget, input bit chk_space);
    int cyc;
    int last;
    exp_t e;
    cyc       = 0;
    last      = -1;
    busy_cnt  = 0;
    first_ack = -1;
    while ((pending() || exp_q.size() != 0) && cyc < budget) begin
      @(negedge i_clk);
      cyc++;
      if (o_busy) busy_cnt++;
      if ($countones(o_ack) > 1) chk("ack_onehot", $countones(o_ack), 1);
      for (int k = 0; k < NC; k++) begin
        if (o_ack[k]) begin
          if (first_ack < 0) first_ack = cyc;
          if (chk_space && last >= 0) chk("ack_spacing", cyc - last, 3);
          last = cyc;
          if (exp_q.size() == 0) begin
            chk("ack_unexpected", k, -1);
          end else begin
            e = exp_q.pop_front();
            chk("ack_core", k, e.core);
            if (e.chk_rd) chk("rdata", int'(o_dram_rdata[8*k +: 8]), int'(e.data));
          end
          if (hold[k] > 1) hold[k]--;
          else clr_req(k);
        end
      end
    end
    if (cyc >= budget) begin
      chk("timeout", cyc, -1);
      for (int k = 0; k < NC; k++) clr_req(k);
      exp_q.delete();
    end
    @(negedge i_clk);
    chk("busy_drop", int'(o_busy), 0);
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    exp_err      = 0;
    i_rst        = 1'b1;
    i_dram_addr  = '0;
    i_dram_read  = '0;
    i_dram_write = '0;
    i_dram_wdata = '0;
    for (int k = 0; k < NC; k++) hold[k] = 0;

`ifdef DRAM_RESP_ERR_EN
    exp_err = 1;
`endif

    // Reset state
    repeat (3) @(negedge i_clk);
    chk("rst_ack", int'(o_ack), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_rdata", int'(o_dram_rdata), 0);
    chk("rst_err", int'(o_err), 0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Single core write then read, latency and busy width
    set_req(0, 2'b00, 2'b01, 16'h0010, 8'hA5, 1);
    push(0, 1'b0, 8'h00);
    service(50, 1'b0);
    chk("t1_wr_latency", first_ack, 2);
    chk("t1_wr_busy", busy_cnt, 2);
    set_req(0, 2'b01, 2'b00, 16'h0010, 8'h00, 1);
    push(0, 1'b1, 8'hA5);
    service(50, 1'b0);
    chk("t1_rd_latency", first_ack, 2);
    chk("t1_rd_busy", busy_cnt, 2);

    // Preload 0x100..0x103 one core at a time (pointer ends at 0)
    for (int k = 0; k < NC; k++) begin
      set_req(k, 2'b00, 2'b01, 16'h0100 + 16'(k), 8'hC0 + 8'(k), 1);
      push(k, 1'b0, 8'h00);
      service(50, 1'b0);
    end

    // Simultaneous reads: order 0,1,2,3 spaced 3 cycles
    for (int k = 0; k < NC; k++) begin
      set_req(k, 2'b01, 2'b00, 16'h0100 + 16'(k), 8'h00, 1);
      push(k, 1'b1, 8'hC0 + 8'(k));
    end
    service(100, 1'b1);

    // Pointer to 2 via core 1, then core 2 continuous with 0 and 3
    set_req(1, 2'b00, 2'b01, 16'h0000, 8'h11, 1);
    push(1, 1'b0, 8'h00);
    service(50, 1'b0);
    set_req(2, 2'b00, 2'b01, 16'h0200, 8'h22, 2);
    set_req(0, 2'b00, 2'b01, 16'h0201, 8'h20, 1);
    set_req(3, 2'b00, 2'b01, 16'h0203, 8'h23, 1);
    push(2, 1'b0, 8'h00);
    push(3, 1'b0, 8'h00);
    push(0, 1'b0, 8'h00);
    push(2, 1'b0, 8'h00);
    service(100, 1'b1);
    chk("pre_oor_err", int'(o_err), 0);

    // Out-of-range read/write must not alias onto low addresses
    set_req(0, 2'b00, 2'b01, 16'h0001, 8'h22, 1);
    push(0, 1'b0, 8'h00);
    service(50, 1'b0);
    set_req(0, 2'b01, 2'b00, 16'h0400, 8'h00, 1);
    push(0, 1'b1, 8'h00);
    service(50, 1'b0);
    chk("oor_err", int'(o_err), exp_err);
    set_req(0, 2'b00, 2'b01, 16'h0401, 8'hEE, 1);
    push(0, 1'b0, 8'h00);
    service(50, 1'b0);
    set_req(0, 2'b01, 2'b00, 16'h0001, 8'h00, 1);
    push(0, 1'b1, 8'h22);
    service(50, 1'b0);
    set_req(0, 2'b01, 2'b00, 16'h0000, 8'h00, 1);
    push(0, 1'b1, 8'h11);
    service(50, 1'b0);
    chk("oor_err_sticky", int'(o_err), exp_err);

    // Reset during ACCESS of a write: abandoned, pointer back to 0
    set_req(2, 2'b00, 2'b01, 16'h0005, 8'h55, 1);
    push(2, 1'b0, 8'h00);
    service(50, 1'b0);
    set_req(1, 2'b00, 2'b01, 16'h0040, 8'h01, 1);
    push(1, 1'b0, 8'h00);
    service(50, 1'b0);
    set_req(0, 2'b00, 2'b01, 16'h0005, 8'h3C, 1);
    @(posedge i_clk);
    #1;
    chk("rst_mid_granted", int'(o_busy), 1);
    i_rst = 1'b1;
    #1;
    chk("rst_mid_busy", int'(o_busy), 0);
    chk("rst_mid_ack", int'(o_ack), 0);
    chk("rst_mid_rdata", int'(o_dram_rdata), 0);
    chk("rst_mid_err", int'(o_err), 0);
    @(negedge i_clk);
    clr_req(0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("post_rst_ack", int'(o_ack), 0);
    set_req(3, 2'b01, 2'b00, 16'h0040, 8'h00, 1);
    set_req(0, 2'b01, 2'b00, 16'h0005, 8'h00, 1);
    push(0, 1'b1, 8'h55);
    push(3, 1'b1, 8'h01);
    service(100, 1'b1);

    // Read+write on one core: write wins, rdata untouched, single ack
    set_req(1, 2'b01, 2'b00, 16'h0001, 8'h00, 1);
    push(1, 1'b1, 8'h22);
    service(50, 1'b0);
    chk("rw_pre_err", int'(o_err), 0);
    set_req(1, 2'b01, 2'b01, 16'h0020, 8'h7E, 1);
    push(1, 1'b1, 8'h22);
    service(50, 1'b0);
    chk("rw_err", int'(o_err), exp_err);
    set_req(1, 2'b01, 2'b00, 16'h0020, 8'h00, 1);
    push(1, 1'b1, 8'h7E);
    service(50, 1'b0);

    // Error flag clears only on reset
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("final_rst_err", int'(o_err), 0);
    i_rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
